// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared constants and types for the data-memory responder
package mem_pkg;

  // Bit positions inside the 3-bit memory exception code
  localparam int MEM_EXC_MISALIGN = 0;
  localparam int MEM_EXC_RANGE    = 1;
  localparam int MEM_EXC_RO       = 2;

  // Largest supported request-to-response latency and the counter width that holds it
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between MEM-stage initiator and responder
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [2:0]  resp_exception;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_exception
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_exception
  );

endinterface

// File: rtl/data_mem_responder_bram_be.sv
// rtl/data_mem_responder_bram_be.sv - single-port RAM, 32-bit words, byte-lane writes, registered read
module bram_be #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [3:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  // Read-before-write port; the read register only moves when enabled so it holds between accesses
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_we[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory port responder: exception check, RAM access, timed response
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RO_WORDS   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam logic [31:0]      RAM_BYTES = 32'(4) << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LATENCY - 1);

  mem_state_e       r_state;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic             r_rd_sel;
  logic [2:0]       r_exc;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0] w_off;
  logic        w_in_range;
  logic        w_ro_hit;
  logic [2:0]  w_exc;
  logic        w_accept;
  logic [3:0]  w_we;
  logic [31:0] w_ram_q;

  // Offset from the window base; addresses below the base wrap high and land out of range
  assign w_off      = bus.req_addr - BASE_ADDR;
  assign w_in_range = w_off < RAM_BYTES;

  if (RO_WORDS > 0) begin : g_ro
    assign w_ro_hit = {2'b00, w_off[31:2]} < 32'(RO_WORDS);
  end else begin : g_no_ro
    assign w_ro_hit = 1'b0;
  end

  // Exception bits are independent; each one is set by its own rule
  always_comb begin
    w_exc                   = 3'b000;
    w_exc[MEM_EXC_MISALIGN] = bus.req_addr[1:0] != 2'b00;
    w_exc[MEM_EXC_RANGE]    = !w_in_range;
    w_exc[MEM_EXC_RO]       = bus.req_write && w_in_range && w_ro_hit;
  end

  // The RAM is touched only in the accept cycle; faulting stores write no lanes
  assign w_accept = !rst && (r_state == IDLE) && bus.req_valid;
  assign w_we     = (w_accept && bus.req_write && (w_exc == 3'b000)) ? bus.req_be : 4'b0000;

  bram_be #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_accept),
    .i_we    (w_we),
    .i_addr  (w_off[ADDR_WIDTH+1:2]),
    .i_wdata (bus.req_wdata),
    .o_rdata (w_ram_q)
  );

  // Request/response sequencing; the RAM read register doubles as the held load data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_exc        <= 3'b000;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_exc       <= w_exc;
            r_rd_sel    <= !bus.req_write && (w_exc == 3'b000);
            if (LATENCY == 1) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_exception = r_exc;
  assign bus.resp_rdata     = r_rd_sel ? w_ram_q : 32'h0000_0000;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder over three configurations
module tb_data_mem_responder;

  localparam int          LAT_T  [3] = '{1, 3, 4};
  localparam logic [31:0] BASE_T [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
  localparam int          RO_T   [3] = '{4, 2, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  sel;
  logic        tb_req_valid, tb_write, tb_resp_ready;
  logic [31:0] tb_addr, tb_wdata;
  logic [3:0]  tb_be;

  logic        rdy_a [3];
  logic        vld_a [3];
  logic [31:0] rd_a  [3];
  logic [2:0]  ex_a  [3];

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    data_mem_responder_if bus ();
    assign bus.req_valid  = tb_req_valid && (sel == 2'(g));
    assign bus.resp_ready = tb_resp_ready && (sel == 2'(g));
    assign bus.req_write  = tb_write;
    assign bus.req_addr   = tb_addr;
    assign bus.req_wdata  = tb_wdata;
    assign bus.req_be     = tb_be;
    data_mem_responder #(
      .ADDR_WIDTH (6),
      .LATENCY    (LAT_T[g]),
      .BASE_ADDR  (BASE_T[g]),
      .RO_WORDS   (RO_T[g])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign rdy_a[g] = bus.req_ready;
    assign vld_a[g] = bus.resp_valid;
    assign rd_a[g]  = bus.resp_rdata;
    assign ex_a[g]  = bus.resp_exception;
  end

  logic        d_req_ready, d_resp_valid;
  logic [31:0] d_rdata;
  logic [2:0]  d_exc;
  assign d_req_ready  = rdy_a[sel];
  assign d_resp_valid = vld_a[sel];
  assign d_rdata      = rd_a[sel];
  assign d_exc        = ex_a[sel];

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          acc = 0;
  bit          busy = 1'b0;
  logic [31:0] exp_rdata, exp_mask;
  logic [2:0]  exp_exc;
  logic [31:0] mmem [3][64];
  bit   [3:0]  kn   [3][64];

  function automatic logic [2:0] ref_exc(input int c, input logic wr, input logic [31:0] a);
    logic [31:0] off;
    logic [2:0]  e;
    off = a - BASE_T[c];
    e = 3'b000;
    if (a % 4 != 0) e[0] = 1'b1;
    if (off >= 32'd256) e[1] = 1'b1;
    else if (wr && (off / 4) < 32'(RO_T[c])) e[2] = 1'b1;
    return e;
  endfunction

  function automatic int widx(input int c, input logic [31:0] a);
    return int'(((a - BASE_T[c]) / 4) % 64);
  endfunction

  function automatic logic [31:0] lane_mask(input bit [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (busy) begin
      if ((cyc - acc >= LAT_T[sel] - 1) && tb_resp_ready) busy <= 1'b0;
    end else if (tb_req_valid) begin
      busy    <= 1'b1;
      acc     <= cyc + 1;
      exp_exc <= ref_exc(sel, tb_write, tb_addr);
      if (tb_write || ref_exc(sel, tb_write, tb_addr) != 3'b000) begin
        exp_rdata <= 32'h0;
        exp_mask  <= 32'hFFFF_FFFF;
      end else begin
        exp_rdata <= mmem[sel][widx(sel, tb_addr)];
        exp_mask  <= lane_mask(kn[sel][widx(sel, tb_addr)]);
      end
      if (tb_write && ref_exc(sel, tb_write, tb_addr) == 3'b000) begin
        for (int i = 0; i < 4; i++) begin
          if (tb_be[i]) begin
            mmem[sel][widx(sel, tb_addr)][8*i +: 8] <= tb_wdata[8*i +: 8];
            kn[sel][widx(sel, tb_addr)][i]          <= 1'b1;
          end
        end
      end
    end
    cyc <= cyc + 1;
  end

  // ---------------- compare process ----------------
  int          total = 0;
  int          bad   = 0;
  int          ncyc  = 0;
  bit          chk_en = 1'b0;
  bit          done   = 1'b0;
  int          lit_seq = 0;
  int          lit_seen = 0;
  string       lit_name;
  logic [31:0] lit_act, lit_exp;

  initial begin
    logic exp_valid;
    forever begin
      @(negedge clk);
      ncyc++;
      if (chk_en) begin
        exp_valid = busy && (cyc - acc >= LAT_T[sel] - 1);
        total++;
        if (d_req_ready !== !busy) begin
          bad++;
          $display("FAIL req_ready cfg%0d cyc%0d: got %b want %b", sel, ncyc, d_req_ready, !busy);
        end
        total++;
        if (d_resp_valid !== exp_valid) begin
          bad++;
          $display("FAIL resp_valid cfg%0d cyc%0d: got %b want %b", sel, ncyc, d_resp_valid, exp_valid);
        end
        if (exp_valid) begin
          total++;
          if ((d_rdata & exp_mask) !== (exp_rdata & exp_mask)) begin
            bad++;
            $display("FAIL resp_rdata cfg%0d cyc%0d: got %h want %h (mask %h)", sel, ncyc, d_rdata, exp_rdata, exp_mask);
          end
          total++;
          if (d_exc !== exp_exc) begin
            bad++;
            $display("FAIL resp_exception cfg%0d cyc%0d: got %b want %b", sel, ncyc, d_exc, exp_exc);
          end
        end
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        total++;
        if (lit_act !== lit_exp) begin
          bad++;
          $display("FAIL %s cfg%0d: got %h want %h", lit_name, sel, lit_act, lit_exp);
        end
      end
      if (done || ncyc > 60000) begin
        if (!done) begin
          bad++;
          $display("FAIL watchdog: got cycle %0d want completion", ncyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_name = nm;
    lit_act  = act;
    lit_exp  = exp;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                      input int stall, output logic [31:0] rd, output logic [2:0] ex, output int lat);
    int n;
    tb_req_valid  = 1'b1;
    tb_write      = wr;
    tb_addr       = a;
    tb_wdata      = wd;
    tb_be         = be;
    tb_resp_ready = 1'b0;
    n = 0;
    while (d_req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) lit("accept_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    tb_req_valid = 1'b0;
    lat = 1;
    n = 0;
    while (d_resp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; lat++; n++;
    end
    if (n >= 50) lit("resp_timeout", 32'(n), 32'(0));
    repeat (stall) begin
      tb_req_valid = 1'($urandom_range(0, 1));
      tb_addr      = $urandom;
      @(posedge clk); #1;
    end
    tb_req_valid = 1'b0;
    rd = d_rdata;
    ex = d_exc;
    tb_resp_ready = 1'b1;
    @(posedge clk); #1;
    tb_resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, a, base;
    logic [2:0]  ex;
    int          lat, nresp, r;
    sel = 2'd0; tb_req_valid = 1'b0; tb_write = 1'b0; tb_resp_ready = 1'b0;
    tb_addr = 32'h0; tb_wdata = 32'h0; tb_be = 4'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    for (int c = 0; c < 3; c++) begin
      sel = 2'(c);
      #1;
      lit("rst_req_ready", 32'(d_req_ready), 32'(1));
      lit("rst_resp_valid", 32'(d_resp_valid), 32'(0));
      lit("rst_rdata", d_rdata, 32'h0);
      lit("rst_exc", 32'(d_exc), 32'(0));
    end

    // cfg0: LATENCY=1, BASE=0, RO_WORDS=4
    sel = 2'd0;
    xact(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, ex, lat);
    lit("st_lat", 32'(lat), 32'(1));
    lit("st_exc", 32'(ex), 32'(0));
    lit("st_rdata", rd, 32'h0);
    xact(0, 32'h10, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("ld_lat", 32'(lat), 32'(1));
    lit("ld_rdata", rd, 32'hDEADBEEF);
    lit("ld_exc", 32'(ex), 32'(0));
    xact(1, 32'h20, 32'h11223344, 4'hF, 0, rd, ex, lat);
    xact(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, ex, lat);
    xact(0, 32'h20, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("partial_rdata", rd, 32'h11BB33DD);
    xact(0, 32'h13, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("misalign_exc", 32'(ex), 32'(1));
    lit("misalign_rdata", rd, 32'h0);
    xact(0, 32'h100, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("range_exc", 32'(ex), 32'(2));
    xact(1, 32'h14, 32'h01020304, 4'hF, 0, rd, ex, lat);
    xact(1, 32'h17, 32'h55555555, 4'hF, 0, rd, ex, lat);
    lit("mis_store_exc", 32'(ex), 32'(1));
    xact(0, 32'h14, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("mis_store_unchanged", rd, 32'h01020304);
    xact(1, 32'h14, 32'h99999999, 4'h0, 0, rd, ex, lat);
    lit("be0_exc", 32'(ex), 32'(0));
    xact(0, 32'h14, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("be0_unchanged", rd, 32'h01020304);
    xact(1, 32'h08, 32'h5A5A5A5A, 4'hF, 0, rd, ex, lat);
    lit("ro_exc", 32'(ex), 32'(4));
    xact(0, 32'h08, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("ro_not_written", 32'(rd == 32'h5A5A5A5A), 32'(0));
    xact(1, 32'h0C, 32'h5A5A5A5A, 4'hF, 0, rd, ex, lat);
    lit("ro_last_exc", 32'(ex), 32'(4));
    xact(1, 32'h10, 32'h12345678, 4'hF, 0, rd, ex, lat);
    lit("rw_first_exc", 32'(ex), 32'(0));
    xact(0, 32'h10, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("rw_first_rdata", rd, 32'h12345678);

    // cfg1: LATENCY=3, BASE=0x1000, RO_WORDS=2
    sel = 2'd1;
    xact(1, 32'h1040, 32'h0BADCAFE, 4'hF, 0, rd, ex, lat);
    lit("l3_st_lat", 32'(lat), 32'(3));
    xact(0, 32'h1040, 32'h0, 4'h0, 5, rd, ex, lat);
    lit("l3_ld_lat", 32'(lat), 32'(3));
    lit("l3_stall_rdata", rd, 32'h0BADCAFE);
    xact(0, 32'h0FFC, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("below_base_exc", 32'(ex), 32'(2));
    xact(1, 32'h1003, 32'h1, 4'hF, 0, rd, ex, lat);
    lit("mis_ro_exc", 32'(ex), 32'(5));
    xact(0, 32'h10FC, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("last_word_exc", 32'(ex), 32'(0));
    xact(0, 32'h1100, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("past_end_exc", 32'(ex), 32'(2));

    // cfg2: LATENCY=4, reset while a store waits
    sel = 2'd2;
    #1;
    tb_req_valid = 1'b1; tb_write = 1'b1; tb_addr = 32'h30; tb_wdata = 32'hCAFEF00D; tb_be = 4'hF;
    @(posedge clk); #1;
    tb_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lit("mid_rst_ready", 32'(d_req_ready), 32'(1));
    lit("mid_rst_valid", 32'(d_resp_valid), 32'(0));
    lit("mid_rst_rdata", d_rdata, 32'h0);
    nresp = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (d_resp_valid === 1'b1) nresp++;
    end
    lit("no_stale_resp", 32'(nresp), 32'(0));
    xact(0, 32'h30, 32'h0, 4'h0, 0, rd, ex, lat);
    lit("post_rst_lat", 32'(lat), 32'(4));
    lit("post_rst_rdata", rd, 32'hCAFEF00D);

    // Randomised traffic on each configuration, checked cycle by cycle against the model
    for (int c = 0; c < 3; c++) begin
      sel  = 2'(c);
      base = BASE_T[c];
      for (int k = 0; k < 120; k++) begin
        r = $urandom_range(0, 9);
        if (r <= 6)      a = base + 4 * $urandom_range(0, 63);
        else if (r == 7) a = base + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
        else if (r == 8) a = base + 256 + 4 * $urandom_range(0, 15);
        else             a = base - 4 * $urandom_range(1, 8);
        xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), rd, ex, lat);
      end
    end

    done = 1'b1;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the core's data-memory port. It accepts one load/store request at a time from the MEM-stage initiator and services it against an internal word-addressed RAM with per-byte write enables. After a programmable latency it returns read data and a 3-bit memory exception code; that code feeds the core's mem_exception path into the final exception vector.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words.
LATENCY, 1, cycles from request accept to response valid; legal range 1..15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to the RAM size.
RO_WORDS, 0, number of words from word 0 upward that are read-only; stores to them fault.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  byte enables; bit i selects byte lane i (little-endian)
resp_valid  out  1  response present
resp_ready  in  1  initiator takes the response
resp_rdata  out  32  load data: full word, unmasked
resp_exception  out  3  bit0 misaligned, bit1 out-of-range, bit2 store to read-only

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_exception=0; latency counter=0. RAM contents are not cleared.
- IDLE, req_ready=1:
  - Accept on req_valid&req_ready; latch write, address, wdata and be.
  - Compute the exception at accept.
  - LATENCY=1 goes to RESP; otherwise goes to WAIT with counter=LATENCY-1.
- WAIT, req_ready=0:
  - Counter decrements each cycle.
  - Moves to RESP on the cycle the counter reaches 1.
  - Total accept-to-resp_valid delay is exactly LATENCY cycles.
- RESP:
  - resp_valid=1; resp_rdata and resp_exception are stable until the handshake.
  - On resp_ready, return to IDLE.
  - No accept in the same cycle as resp_ready. Back-to-back issue rate is one request per LATENCY+1 cycles minimum.
- Exception rules, priority-free (bits are OR'd independently):
  - bit0: req_addr[1:0]!=0.
  - bit1: (req_addr-BASE_ADDR) >= 4*2^ADDR_WIDTH, as a 32-bit unsigned compare (wrap-around below BASE counts as out of range).
  - bit2: req_write and in range and word index < RO_WORDS.
- Side effects:
  - Any nonzero exception means the store is suppressed.
  - For loads with a nonzero exception, resp_rdata=0.
  - req_be=0 on a store is legal: no bytes change, no exception.
- Store commit:
  - The RAM write happens in the accept cycle, one write per enabled lane.
  - resp_rdata for a store is 0.
- Load read:
  - The RAM is read at accept (1-cycle synchronous RAM).
  - Data is held in a response register until the handshake.
- Ordering: a load following a store to the same word returns the stored data, because the store completes before the next accept.
- Loads ignore req_be; the lane select/sign extend is done by the initiator.
- Reset mid-operation:
  - Any WAIT/RESP transaction is dropped and its response never appears.
  - A store accepted before reset has already committed.
- req_valid while req_ready=0 is ignored. The initiator must hold its request until accepted.

Decomposition:
- Shared package mem_pkg:
  - exception bit indices MEM_EXC_MISALIGN=0, MEM_EXC_RANGE=1, MEM_EXC_RO=2;
  - FSM state encoding (2-bit, IDLE=0, WAIT=1, RESP=2);
  - the LATENCY upper bound constant.
- One natural sub-module, bram_be:
  - single-port synchronous RAM, 32-bit words, 4 byte-lane write enables, registered read;
  - parameterised by ADDR_WIDTH.
- The FSM, exception logic and response register live in data_mem_responder.

Test Plan:
- LATENCY=1: store addr 0x10, wdata 0xDEADBEEF, be 4'b1111, then load 0x10 -> resp_valid exactly 1 cycle after each accept; load rdata=0xDEADBEEF, exception=0.
- Partial store: preload 0x20=0x11223344; store wdata 0xAABBCCDD, be 4'b0101; load 0x20 -> rdata=0x11BB33DD.
- Misaligned/range: load 0x13 -> exception=3'b001, rdata=0. Load BASE+4*2^ADDR_WIDTH -> exception=3'b010. Store 0x17 with be 4'b1111 -> 3'b001 and memory unchanged.
- RO_WORDS=4: store to 0x08 -> exception=3'b100, word unchanged; store to 0x10 -> exception 0, committed.
- LATENCY=3 with resp_ready held low 5 cycles -> resp_valid rises 3 cycles after accept; rdata/exception stable across the stall; req_ready=0 throughout; req_valid pulses during the stall are ignored.
- Assert rst while in WAIT (LATENCY=4) -> next cycle state IDLE, req_ready=1, resp_valid=0, and no response ever issued. A store accepted just before the reset is readable afterwards.
